// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: ID-stage branch sequencer with a 2-bit counter predictor, load-use stall and stats.
module branch_predict_ctrl #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       IF_pc,
  input  logic              IF_isBranch,
  output logic              pred_taken,
  input  logic              ID_valid,
  input  logic              ID_isBranch,
  input  logic              ID_isJump,
  input  logic [31:0]       ID_pc,
  input  logic              ID_pred,
  input  logic              ID_taken,
  input  logic              ID_ldHazard,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        redirect_sel,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] br_cnt,
  output logic [PERF_W-1:0] misp_cnt
);
  localparam int N = 1 << IDX_W;
  typedef enum logic {RUN, HOLD} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q [N];
  logic [1:0]        cnt_d [N];
  logic [PERF_W-1:0] br_cnt_q, br_cnt_d, misp_cnt_q, misp_cnt_d;
  logic [IDX_W-1:0]  if_idx, id_idx;
  logic [1:0]        cur, upd;
  logic              br_v, res, miss, jmp;
  logic              unused_pc;
  assign unused_pc = ^{IF_pc[31:IDX_W+2], IF_pc[1:0], ID_pc[31:IDX_W+2], ID_pc[1:0]};
  assign if_idx = IF_pc[IDX_W+1:2];
  assign id_idx = ID_pc[IDX_W+1:2];
  assign cur    = cnt_q[id_idx];
  assign upd    = ID_taken ? (cur == 2'b11 ? 2'b11 : cur + 2'b01) : (cur == 2'b00 ? 2'b00 : cur - 2'b01);
  // Outputs are gated by reset_n so a reset mid-HOLD drops stall without waiting for a clock.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    res     = 1'b0;
    br_v    = reset_n & ID_valid & ID_isBranch;
    if (state_q == RUN) begin
      stall   = br_v & ID_ldHazard;
      res     = br_v & ~ID_ldHazard;
      state_d = (br_v & ID_ldHazard) ? HOLD : RUN;
    end else begin
      stall   = br_v & ID_ldHazard;
      res     = br_v & ~ID_ldHazard;
      state_d = (br_v & ID_ldHazard) ? HOLD : RUN;
    end
  end
  assign miss         = res & (ID_pred != ID_taken);
  assign jmp          = reset_n & ID_valid & ID_isJump & ~stall;
  assign flush        = miss | jmp;
  assign redirect_sel = miss ? (ID_taken ? 2'b01 : 2'b10) : {1'b0, jmp};
  assign pred_taken   = IF_isBranch & ((res && if_idx == id_idx) ? upd[1] : cnt_q[if_idx][1]);
  always_comb begin
    cnt_d = cnt_q;
    if (res) cnt_d[id_idx] = upd;
  end
  assign br_cnt_d   = perf_clr ? '0 : (res && ~&br_cnt_q) ? br_cnt_q + PERF_W'(1) : br_cnt_q;
  assign misp_cnt_d = perf_clr ? '0 : (miss && ~&misp_cnt_q) ? misp_cnt_q + PERF_W'(1) : misp_cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      state_q    <= state_d;
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
      cnt_q      <= cnt_d;
    end
  end
  assign br_cnt   = br_cnt_q;
  assign misp_cnt = misp_cnt_q;
endmodule
